out_seq_cmd: RTL and testbench
==============================

# out_seq_cmd

Parametrised output-sequence command handler: the successor to the single-strobe output command task. It accepts one task carrying 1..MAX_ENTRIES output entries (channel + strobe), buffers and validates the whole payload, then streams one output command word per entry on the command stream. It returns exactly one response code (task_icd_pkg) per accepted task. It sits between the task parser (task + payload stream) and the command stream sink.

## Interface
- NUM_CH, 4, number of output channels addressable (1..16)
- MAX_ENTRIES, 8, buffer depth / max entries per task (1..64)
- STROBE_W, 5, strobe field width in bits (1..24)
- TIMEOUT_CYCLES, 1000, stall limit in clock ticks for payload load and per command word
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- task_valid  in  1  task strobe; sampled only while task_ready=1
- task_ready  out  1  high only in IDLE
- len_bytes  in  32  task length including header
- asi_pay_valid  in  1  payload word valid
- asi_pay_ready  out  1  payload word accept; high only in LOAD
- asi_pay_data  in  32  payload word: [27:24] channel, [STROBE_W-1:0] strobe, all other bits zero
- resp_valid  out  1  one-cycle response pulse
- resp  out  32  response code; holds last value between pulses
- aso_cmd_ready  in  1  command sink ready
- aso_cmd_valid  out  1  command word valid
- aso_cmd_data  out  32  [31:28]=4'b0001, [27:24]=channel, [STROBE_W-1:0]=strobe, rest zero

## Operation
- Entry count n = len_bytes/4 − HEADER_WORDS.
- States: IDLE, CHECK, LOAD, SRC.
- IDLE: on task_valid, register len_bytes and go to CHECK.
- CHECK: len_bytes is valid if it is a multiple of 4 and 1 ≤ n ≤ MAX_ENTRIES.
  - Invalid: resp=HEADER_INVALID and return to IDLE. No payload is consumed; the parser discards it.
  - Valid: clear write pointer, error flag and timeout counter, then go to LOAD.
- LOAD: asi_pay_ready=1.
  - Each handshake writes the word into buffer[wr_ptr], increments wr_ptr, and clears the timeout counter.
  - The error flag is set if channel ≥ NUM_CH or any reserved bit is nonzero.
  - After n words: if the error flag is set, resp=PAYLOAD_INVALID and go to IDLE; no command is emitted. Otherwise go to SRC with rd_ptr=0.
  - TIMEOUT_CYCLES consecutive cycles without a handshake: resp=EXE_ERROR, go to IDLE.
- SRC: aso_cmd_valid=1 with aso_cmd_data built from buffer[rd_ptr].
  - On handshake, rd_ptr increments and the timeout counter clears.
  - After the handshake on entry n−1: resp=TASK_VALID, go to IDLE.
  - Timeout counter reaching TIMEOUT_CYCLES with no handshake: resp=EXE_ERROR, deassert valid, discard remaining entries, go to IDLE.
- Pointers are $clog2(MAX_ENTRIES+1) bits and never wrap within a task.
- The timeout counter is 32 bits and saturates.

## Timing
- Reset values:
  - task_ready=1, asi_pay_ready=0, aso_cmd_valid=0, resp_valid=0.
  - resp=0, aso_cmd_data fields=0, state=IDLE.
- Reset asserted mid-task: the task is abandoned, no response is issued, and buffer contents are don't-care.
- Task accepted at edge E: CHECK occupies cycle E+1.
  - Header error: resp_valid is high in cycle E+2.
  - Valid header: asi_pay_ready rises in cycle E+2.
- Last payload handshake at edge P:
  - aso_cmd_valid rises in cycle P+1 (registered), or resp_valid=PAYLOAD_INVALID in cycle P+1.
- Command words stream back-to-back while aso_cmd_ready=1: n words in n cycles.
  - aso_cmd_data is stable while valid=1 and ready=0.
- Final handshake at edge C: aso_cmd_valid=0 and resp_valid=1 (TASK_VALID) in cycle C+1; task_ready=1 in the same cycle.
  - Earliest next task accept is at the end of cycle C+1.
- Timeout fires when the counter equals TIMEOUT_CYCLES.
  - resp_valid and aso_cmd_valid=0 appear the following cycle.
  - A handshake in the same cycle as counter==TIMEOUT_CYCLES wins: the word is counted and the counter clears.
- resp_valid is never high in two consecutive cycles.
- task_valid is ignored outside IDLE.

## Test plan
- Nominal, HEADER_WORDS=h, len=(h+3)*4, payload {ch0 s5, ch3 s31, ch1 s0}, ready=1 → 3 command words 0x10000005, 0x1300001F, 0x11000000 on consecutive cycles, then a single TASK_VALID pulse.
- Header errors: len=h*4 (n=0), len=(h+9)*4 with MAX_ENTRIES=8, and len=(h+1)*4+2 → HEADER_INVALID 2 cycles after accept for each; asi_pay_ready never rises.
- Payload error: n=4, with the 2nd word channel=4 (NUM_CH=4) and the 3rd word bit 8 set → all 4 words consumed, no aso_cmd_valid, PAYLOAD_INVALID pulse.
- Backpressure and timeout: n=2, ready toggles for word 0 (data held stable), then ready=0 → word 0 delivered, EXE_ERROR after TIMEOUT_CYCLES, valid drops; a handshake at counter==TIMEOUT_CYCLES in a separate run → accepted.
- Payload stall: asi_pay_valid=0 after 1 of 3 words → EXE_ERROR after TIMEOUT_CYCLES; a task_valid asserted during LOAD is ignored.
- Reset: drop rst_n mid-SRC with ready=0 → all outputs return to reset values immediately with no response pulse; a following nominal task completes correctly.

Source files
------------

// File: rtl/out_seq_cmd.sv
// Output-sequence command handler: buffers and validates a task's entry list, then
// streams one command word per entry and returns exactly one response per task.
module out_seq_cmd #(
  parameter int          NUM_CH          = 4,
  parameter int          MAX_ENTRIES     = 8,
  parameter int          STROBE_W        = 5,
  parameter int          TIMEOUT_CYCLES  = 1000,
  parameter int          HEADER_WORDS    = 2,
  parameter logic [31:0] RESP_TASK_VALID = 32'h0000_0001,
  parameter logic [31:0] RESP_HDR_INV    = 32'h0000_0002,
  parameter logic [31:0] RESP_PAY_INV    = 32'h0000_0003,
  parameter logic [31:0] RESP_EXE_ERR    = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        task_valid,
  output logic        task_ready,
  input  logic [31:0] len_bytes,
  input  logic        asi_pay_valid,
  output logic        asi_pay_ready,
  input  logic [31:0] asi_pay_data,
  output logic        resp_valid,
  output logic [31:0] resp,
  input  logic        aso_cmd_ready,
  output logic        aso_cmd_valid,
  output logic [31:0] aso_cmd_data
);

  // state   | meaning
  // IDLE    | waiting for a task header
  // CHECK   | validating len_bytes
  // LOAD    | accepting n payload words into the buffer
  // SRC     | streaming command words to the sink
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_SRC   = 2'd3;

  localparam int PTR_W = $clog2(MAX_ENTRIES + 1);
  localparam int IDX_W = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int ENT_W = 4 + STROBE_W;
  localparam logic [31:0] FIELD_MASK = 32'h0F00_0000 | ((32'h1 << STROBE_W) - 32'h1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      len_q, len_d;
  logic [PTR_W-1:0] n_q, n_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic [31:0]      tmo_q, tmo_d;
  logic [31:0]      resp_q, resp_d;
  logic             resp_valid_q, resp_valid_d;

  logic [ENT_W-1:0] entry_q [DEPTH];
  logic             entry_we;
  logic [ENT_W-1:0] pay_entry;
  logic [ENT_W-1:0] rd_entry;

  logic [31:0] words;
  logic        hdr_ok;
  logic        word_err;
  logic        tmo_hit;
  logic [31:0] tmo_inc;
  logic        wr_last;
  logic        rd_last;

  always_comb begin
    words    = {2'b00, len_q[31:2]};
    hdr_ok   = (len_q[1:0] == 2'b00) &&
               (words >= 32'(HEADER_WORDS + 1)) &&
               (words <= 32'(HEADER_WORDS + MAX_ENTRIES));
    word_err = ({28'd0, asi_pay_data[27:24]} >= 32'(NUM_CH)) ||
               ((asi_pay_data & ~FIELD_MASK) != 32'd0);
    pay_entry = {asi_pay_data[27:24], asi_pay_data[STROBE_W-1:0]};
    rd_entry  = entry_q[rd_ptr_q[IDX_W-1:0]];
    tmo_hit   = (tmo_q == 32'(TIMEOUT_CYCLES));
    tmo_inc   = (tmo_q == 32'hFFFF_FFFF) ? tmo_q : tmo_q + 32'd1;
    wr_last   = ((wr_ptr_q + PTR_W'(1)) == n_q);
    rd_last   = ((rd_ptr_q + PTR_W'(1)) == n_q);
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    n_d          = n_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q;
    tmo_d        = tmo_q;
    resp_d       = resp_q;
    resp_valid_d = 1'b0;
    entry_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (task_valid) begin
          len_d   = len_bytes;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hdr_ok) begin
          n_d      = PTR_W'(words - 32'(HEADER_WORDS));
          wr_ptr_d = '0;
          err_d    = 1'b0;
          tmo_d    = 32'd0;
          state_d  = S_LOAD;
        end else begin
          resp_d       = RESP_HDR_INV;
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_LOAD: begin
        // a handshake in the timeout cycle still counts
        if (asi_pay_valid) begin
          entry_we = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          tmo_d    = 32'd0;
          err_d    = err_q | word_err;
          if (wr_last) begin
            if (err_q | word_err) begin
              resp_d       = RESP_PAY_INV;
              resp_valid_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              rd_ptr_d = '0;
              state_d  = S_SRC;
            end
          end
        end else if (tmo_hit) begin
          resp_d       = RESP_EXE_ERR;
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: begin
        if (aso_cmd_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          tmo_d    = 32'd0;
          if (rd_last) begin
            resp_d       = RESP_TASK_VALID;
            resp_valid_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else if (tmo_hit) begin
          resp_d       = RESP_EXE_ERR;
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= 32'd0;
      n_q          <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      tmo_q        <= 32'd0;
      resp_q       <= 32'd0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      n_q          <= n_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (entry_we) begin
      entry_q[wr_ptr_q[IDX_W-1:0]] <= pay_entry;
    end
  end

  always_comb begin
    task_ready    = (state_q == S_IDLE);
    asi_pay_ready = (state_q == S_LOAD);
    aso_cmd_valid = (state_q == S_SRC);
    resp_valid    = resp_valid_q;
    resp          = resp_q;
    aso_cmd_data  = 32'd0;
    if (state_q == S_SRC) begin
      aso_cmd_data = 32'h1000_0000 | {4'd0, rd_entry[ENT_W-1 -: 4], 24'd0} |
                     32'(rd_entry[STROBE_W-1:0]);
    end
  end

endmodule

// File: tb/tb_out_seq_cmd.sv
// Directed bench for out_seq_cmd: nominal stream, header/payload errors,
// backpressure, timeouts and mid-task reset.
module tb_out_seq_cmd;
  localparam int T = 20;
  localparam logic [31:0] TV = 32'h1;
  localparam logic [31:0] HI = 32'h2;
  localparam logic [31:0] PI = 32'h3;
  localparam logic [31:0] EE = 32'h4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        task_valid;
  logic        task_ready;
  logic [31:0] len_bytes;
  logic        asi_pay_valid;
  logic        asi_pay_ready;
  logic [31:0] asi_pay_data;
  logic        resp_valid;
  logic [31:0] resp;
  logic        aso_cmd_ready;
  logic        aso_cmd_valid;
  logic [31:0] aso_cmd_data;

  int total = 0;
  int bad   = 0;

  out_seq_cmd #(
    .NUM_CH(4), .MAX_ENTRIES(8), .STROBE_W(5), .TIMEOUT_CYCLES(T), .HEADER_WORDS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .task_valid(task_valid), .task_ready(task_ready), .len_bytes(len_bytes),
    .asi_pay_valid(asi_pay_valid), .asi_pay_ready(asi_pay_ready), .asi_pay_data(asi_pay_data),
    .resp_valid(resp_valid), .resp(resp),
    .aso_cmd_ready(aso_cmd_ready), .aso_cmd_valid(aso_cmd_valid), .aso_cmd_data(aso_cmd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Accept a task header and step through CHECK into the following cycle.
  task automatic accept(input logic [31:0] len);
    chk("task_ready_idle", {31'd0, task_ready}, 32'd1);
    task_valid = 1'b1;
    len_bytes  = len;
    tick();
    task_valid = 1'b0;
    chk("task_ready_check", {31'd0, task_ready}, 32'd0);
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    chk("pay_ready", {31'd0, asi_pay_ready}, 32'd1);
    asi_pay_valid = 1'b1;
    asi_pay_data  = w;
    tick();
    asi_pay_valid = 1'b0;
    asi_pay_data  = 32'd0;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] code);
    chk({tag, "_rv"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_code"}, resp, code);
    chk({tag, "_cv"}, {31'd0, aso_cmd_valid}, 32'd0);
    chk({tag, "_tr"}, {31'd0, task_ready}, 32'd1);
    tick();
    chk({tag, "_rv_drop"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_hold"}, resp, code);
  endtask

  logic [31:0] bad_lens [3];

  initial begin
    rst_n = 1'b0; task_valid = 1'b0; len_bytes = 32'd0;
    asi_pay_valid = 1'b0; asi_pay_data = 32'd0; aso_cmd_ready = 1'b0;
    tick(); tick();
    chk("rst_task_ready", {31'd0, task_ready}, 32'd1);
    chk("rst_pay_ready", {31'd0, asi_pay_ready}, 32'd0);
    chk("rst_cmd_valid", {31'd0, aso_cmd_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp", resp, 32'd0);
    chk("rst_cmd_data", aso_cmd_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // nominal: 3 entries, sink always ready
    aso_cmd_ready = 1'b1;
    accept(32'd20);
    send_word(32'h0000_0005);
    send_word(32'h0300_001F);
    send_word(32'h0100_0000);
    chk("nom_pay_ready_drop", {31'd0, asi_pay_ready}, 32'd0);
    chk("nom_v0", {31'd0, aso_cmd_valid}, 32'd1);
    chk("nom_d0", aso_cmd_data, 32'h1000_0005);
    tick();
    chk("nom_v1", {31'd0, aso_cmd_valid}, 32'd1);
    chk("nom_d1", aso_cmd_data, 32'h1300_001F);
    tick();
    chk("nom_v2", {31'd0, aso_cmd_valid}, 32'd1);
    chk("nom_d2", aso_cmd_data, 32'h1100_0000);
    tick();
    chk_resp("nom", TV);

    // header errors: n=0, n=9, not a multiple of 4
    bad_lens[0] = 32'd8;
    bad_lens[1] = 32'd44;
    bad_lens[2] = 32'd14;
    for (int i = 0; i < 3; i++) begin
      chk("hdr_idle", {31'd0, task_ready}, 32'd1);
      task_valid = 1'b1;
      len_bytes  = bad_lens[i];
      tick();
      task_valid = 1'b0;
      chk("hdr_pr_check", {31'd0, asi_pay_ready}, 32'd0);
      chk("hdr_rv_check", {31'd0, resp_valid}, 32'd0);
      tick();
      chk("hdr_pr", {31'd0, asi_pay_ready}, 32'd0);
      chk_resp("hdr", HI);
    end

    // payload error: channel 4 in word 1, reserved bit 8 in word 2
    aso_cmd_ready = 1'b1;
    accept(32'd24);
    send_word(32'h0000_0001);
    send_word(32'h0400_0002);
    send_word(32'h0000_0103);
    send_word(32'h0200_0004);
    chk("pay_pr_drop", {31'd0, asi_pay_ready}, 32'd0);
    chk_resp("pay", PI);

    // backpressure then sink stall timeout
    aso_cmd_ready = 1'b0;
    accept(32'd16);
    send_word(32'h0200_0009);
    send_word(32'h0100_0011);
    chk("bp_v0", {31'd0, aso_cmd_valid}, 32'd1);
    chk("bp_d0", aso_cmd_data, 32'h1200_0009);
    tick();
    chk("bp_d0_hold", aso_cmd_data, 32'h1200_0009);
    aso_cmd_ready = 1'b1;
    tick();
    aso_cmd_ready = 1'b0;
    chk("bp_d1", aso_cmd_data, 32'h1100_0011);
    for (int i = 0; i <= T; i++) begin
      chk("bp_wait_valid", {31'd0, aso_cmd_valid}, 32'd1);
      tick();
    end
    chk_resp("bp_tmo", EE);

    // handshake in the cycle the counter reaches the limit wins
    accept(32'd12);
    send_word(32'h0300_0001);
    for (int i = 0; i < T; i++) begin
      chk("edge_wait_valid", {31'd0, aso_cmd_valid}, 32'd1);
      tick();
    end
    chk("edge_d", aso_cmd_data, 32'h1300_0001);
    chk("edge_rv", {31'd0, resp_valid}, 32'd0);
    aso_cmd_ready = 1'b1;
    tick();
    aso_cmd_ready = 1'b0;
    chk_resp("edge", TV);

    // payload stall timeout; task_valid during LOAD is ignored
    accept(32'd20);
    send_word(32'h0000_0001);
    task_valid = 1'b1;
    len_bytes  = 32'd12;
    for (int i = 0; i <= T; i++) begin
      if (i == 4) task_valid = 1'b0;
      chk("stall_pr", {31'd0, asi_pay_ready}, 32'd1);
      chk("stall_tr", {31'd0, task_ready}, 32'd0);
      tick();
    end
    chk("stall_pr_drop", {31'd0, asi_pay_ready}, 32'd0);
    chk_resp("stall", EE);
    chk("stall_idle", {31'd0, task_ready}, 32'd1);

    // reset mid-SRC
    aso_cmd_ready = 1'b0;
    accept(32'd16);
    send_word(32'h0000_0003);
    send_word(32'h0100_0004);
    chk("rs_v", {31'd0, aso_cmd_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_cv", {31'd0, aso_cmd_valid}, 32'd0);
    chk("rs_cd", aso_cmd_data, 32'd0);
    chk("rs_tr", {31'd0, task_ready}, 32'd1);
    chk("rs_pr", {31'd0, asi_pay_ready}, 32'd0);
    chk("rs_rv", {31'd0, resp_valid}, 32'd0);
    chk("rs_resp", resp, 32'd0);
    tick(); tick();
    chk("rs_rv_hold", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rs_rv_after", {31'd0, resp_valid}, 32'd0);

    aso_cmd_ready = 1'b1;
    accept(32'd12);
    send_word(32'h0200_0007);
    chk("post_v", {31'd0, aso_cmd_valid}, 32'd1);
    chk("post_d", aso_cmd_data, 32'h1200_0007);
    tick();
    chk_resp("post", TV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
